// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the multi-cycle CPU: one request at a time, a fixed
// number of wait states, then a response the CPU must consume. Backs a word RAM.
module cpu_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        resp_ready
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        write_q, write_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] ram_q [DEPTH];

    logic              in_idle;
    logic              enter_resp;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_be;
    logic              cur_write;
    logic              cur_err;
    logic [ADDR_W-1:0] cur_idx;

    // With zero wait states RESP is entered at the acceptance edge itself, so the
    // request being completed is the live input in IDLE and the latched copy otherwise.
    assign in_idle   = (state_q == S_IDLE);
    assign cur_addr  = in_idle ? req_addr  : addr_q;
    assign cur_wdata = in_idle ? req_wdata : wdata_q;
    assign cur_be    = in_idle ? req_be    : be_q;
    assign cur_write = in_idle ? req_write : write_q;
    assign cur_err   = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_W + 2)) != 32'd0);
    assign cur_idx   = cur_addr[ADDR_W+1:2];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        write_d    = write_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    write_d = req_write;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_write || cur_err) ? 32'd0 : ram_q[cur_idx];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: RAM has no reset; contents survive rst_n, and reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && cur_write && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    ram_q[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed vector table, hand-written
// reset/backpressure sequences, then random traffic against a word-array model.
module tb_cpu_mem_responder;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int LIMIT       = 4 << ADDR_W;
    localparam int MAX_LAT     = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_ready;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_mem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ready"},  32'(req_ready),  32'd1);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_rdata"}, resp_rdata,      32'd0);
        check({tag, " resp_err"},   32'(resp_err),   32'd0);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < MAX_LAT) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    // One full transaction. While the request is pending, garbage is driven on
    // req_* (with req_valid high) to show the inputs are ignored when not ready.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, input bit early_ready,
                          output logic [31:0] rdata, output logic err);
        int lat;
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk); #1;
        req_write  = 1'b1;
        req_addr   = 32'($urandom_range(0, 15)) << 2;
        req_wdata  = $urandom;
        req_be     = 4'hF;
        resp_ready = early_ready;
        lat = 1;
        while (!resp_valid && lat < MAX_LAT) begin
            @(posedge clk); #1;
            lat++;
        end
        check("response latency", 32'(lat), 32'(WAIT_CYCLES + 1));
        rdata      = resp_rdata;
        err        = resp_err;
        resp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("held resp_valid", 32'(resp_valid), 32'd1);
            check("held resp_rdata", resp_rdata, rdata);
            check("held resp_err",   32'(resp_err), 32'(err));
            check("held req_ready",  32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check_idle_outputs("after handshake");
    endtask

    // Behavioural model: a word array indexed by byte address / 4.
    logic [31:0] model_mem [int];

    function automatic void model_access(input logic wr, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be,
                                         output logic [31:0] rdata, output logic err);
        logic [31:0] mask;
        int          word;
        err   = (addr % 4 != 0) || (addr >= 32'(LIMIT));
        word  = int'(addr / 4);
        rdata = 32'd0;
        if (!err) begin
            if (wr) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                model_mem[word] = (model_mem[word] & ~mask) | (wdata & mask);
            end else begin
                rdata = model_mem[word];
            end
        end
    endfunction

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          guard;

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 0, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 5, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 1, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDE22_BE44, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 2, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'h0BAD_F00D, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0012, 32'hAAAA_AAAA, 4'hF, 0, 32'h0,         1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h5555_5555, 4'h0, 0, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDE22_BE44, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 0, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 0, 32'h1234_5678, 1'b0};
        vecs[13] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h0,         1'b1};
        vecs[14] = '{1'b1, 32'h0000_0020, 32'h600D_CAFE, 4'hF, 0, 32'h0,         1'b0};
        vecs[15] = '{1'b1, 32'h0000_0028, 32'h2468_ACE0, 4'hF, 0, 32'h0,         1'b0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b0;

        // Reset held for two cycles, outputs checked during and after.
        @(posedge clk); #1;
        check_idle_outputs("in reset");
        @(posedge clk); #1;
        check_idle_outputs("in reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("after reset");

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, 1'b0, rd, er);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Reset during the first WAIT cycle of a write: the write must be dropped.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("accepted write leaves idle", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("reset in wait");
        rst_n = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check("reset-in-wait read data", rd, 32'h600D_CAFE);
        check("reset-in-wait read err", 32'(er), 32'd0);

        // Reset while a write response is pending: the write has already landed.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h1357_2468; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < MAX_LAT) begin
            @(posedge clk); #1;
            guard++;
        end
        check("pending response before reset", 32'(resp_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("reset in resp");
        rst_n = 1'b1;
        do_req(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check("reset-in-resp read data", rd, 32'h1357_2468);

        // req_valid together with reset: nothing accepted.
        rst_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h28; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        check_idle_outputs("valid during reset");
        @(posedge clk); #1;
        check_idle_outputs("valid during reset +1");
        do_req(1'b0, 32'h28, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check("valid-during-reset read data", rd, 32'h2468_ACE0);

        // Random traffic over words 0..15 plus misaligned and out-of-range addresses.
        for (int w = 0; w < 16; w++) begin
            logic [31:0] d = $urandom;
            model_access(1'b1, 32'(w * 4), d, 4'hF, exp_rd, exp_er);
            do_req(1'b1, 32'(w * 4), d, 4'hF, 0, 1'b0, rd, er);
            check("init write err", 32'(er), 32'(exp_er));
        end
        for (int n = 0; n < 80; n++) begin
            logic        wr   = 1'($urandom_range(0, 1));
            logic [31:0] addr = 32'($urandom_range(0, 15)) << 2;
            logic [31:0] d    = $urandom;
            logic [3:0]  be   = 4'($urandom_range(0, 15));
            int          sel  = $urandom_range(0, 9);
            if (sel == 7) addr = addr | 32'($urandom_range(1, 3));
            else if (sel >= 8) addr = addr | (32'd1 << $urandom_range(12, 31));
            model_access(wr, addr, d, be, exp_rd, exp_er);
            do_req(wr, addr, d, be, $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd, er);
            check($sformatf("rand%0d rdata", n), rd, exp_rd);
            check($sformatf("rand%0d err", n), 32'(er), 32'(exp_er));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
